// File: rtl/runner_game_core.sv
// Game engine for the 160x120 runner: state machine, tick divider, jump physics,
// scrolling obstacle channels with LFSR spawning, collision, lives and score.
module runner_game_core #(
   parameter int unsigned TICK_DIV   = 833333,
   parameter int unsigned H_W        = 7,
   parameter int unsigned JUMP_V     = 6,
   parameter int unsigned GRAVITY    = 1,
   parameter int unsigned N_OBS      = 2,
   parameter int unsigned X_W        = 8,
   parameter int unsigned X_START    = 159,
   parameter int unsigned PLAYER_X   = 20,
   parameter int unsigned OBS_H      = 8,
   parameter int unsigned MIN_GAP    = 24,
   parameter int unsigned LIVES      = 3,
   parameter int unsigned DEAD_TICKS = 60,
   parameter int unsigned SCORE_W    = 16
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start,
   input  logic                   jump,
   output logic [2:0]             state,
   output logic                   tick,
   output logic [H_W-1:0]         player_y,
   output logic [N_OBS*X_W-1:0]   obs_x,
   output logic [N_OBS-1:0]       obs_active,
   output logic [3:0]             lives_left,
   output logic [SCORE_W-1:0]     score,
   output logic                   hit,
   output logic                   game_over
);

   localparam int unsigned DIV_W  = $clog2(TICK_DIV);
   localparam int unsigned GAP_W  = $clog2(MIN_GAP + 1) + 1;
   localparam int unsigned WAIT_W = $clog2(DEAD_TICKS + 1);
   localparam int unsigned CNT_W  = $clog2(N_OBS + 1);
   localparam int unsigned V_W    = H_W + 1;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StInit     = 3'd1,
      StRespawn  = 3'd2,
      StPlay     = 3'd3,
      StHit      = 3'd4,
      StDeadWait = 3'd5,
      StOver     = 3'd6
   } state_e;

   state_e                       state_q;
   logic [DIV_W-1:0]             div_q;
   logic [H_W-1:0]               y_q;
   logic signed [V_W-1:0]        vel_q;
   logic [N_OBS-1:0][X_W-1:0]    x_q;
   logic [N_OBS-1:0]             act_q;
   logic [3:0]                   lives_q;
   logic [SCORE_W-1:0]           score_q;
   logic                         hit_q;
   logic                         over_q;
   logic [15:0]                  lfsr_q;
   logic [GAP_W-1:0]             gap_q;
   logic                         pend_q;
   logic                         jump_prev_q;
   logic [WAIT_W-1:0]            wait_q;

   logic                         jump_edge;
   logic                         jump_now;
   logic signed [V_W-1:0]        vel_eff;
   logic signed [V_W-1:0]        vel_nxt;
   logic signed [H_W+1:0]        y_sum;
   logic [H_W-1:0]               y_nxt;
   logic [N_OBS-1:0][X_W-1:0]    x_nxt;
   logic [N_OBS-1:0]             act_nxt;
   logic [CNT_W-1:0]             cleared;
   logic                         spawn_ok;
   logic                         found;
   logic [GAP_W-1:0]             gap_nxt;
   logic [15:0]                  lfsr_nxt;
   logic                         collide;
   logic [3:0]                   lives_dec;

   assign tick       = (div_q == DIV_W'(TICK_DIV - 1));
   assign jump_edge  = jump & ~jump_prev_q;
   assign lives_dec  = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;

   assign state      = state_q;
   assign player_y   = y_q;
   assign obs_x      = x_q;
   assign obs_active = act_q;
   assign lives_left = lives_q;
   assign score      = score_q;
   assign hit        = hit_q;
   assign game_over  = over_q;

   // Free-running tick divider, active in every state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         div_q <= '0;
      end else if (tick) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   // Previous jump level for edge detection.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         jump_prev_q <= 1'b0;
      end else begin
         jump_prev_q <= jump;
      end
   end

   // Next-tick values for physics, obstacles, spawner and collision in PLAY.
   always_comb begin
      jump_now = (y_q == '0) && pend_q;
      vel_eff  = jump_now ? $signed(V_W'(JUMP_V)) : vel_q;
      y_sum    = $signed({2'b00, y_q}) + $signed({vel_eff[V_W-1], vel_eff});
      y_nxt    = y_sum[H_W-1:0];
      vel_nxt  = vel_eff - $signed(V_W'(GRAVITY));
      if (y_sum[H_W+1] || (y_sum == '0)) begin
         y_nxt   = '0;
         vel_nxt = '0;
      end else if (y_sum[H_W]) begin
         y_nxt   = '1;
         vel_nxt = '0;
      end

      x_nxt   = x_q;
      act_nxt = act_q;
      cleared = '0;
      for (int i = 0; i < N_OBS; i++) begin
         if (act_q[i]) begin
            if (x_q[i] == '0) begin
               act_nxt[i] = 1'b0;
               cleared    = cleared + CNT_W'(1);
            end else begin
               x_nxt[i] = x_q[i] - X_W'(1);
            end
         end
      end

      // Only channels free before this tick may take a new obstacle.
      spawn_ok = (lfsr_q[3:0] == 4'd0) && (gap_q >= GAP_W'(MIN_GAP)) && !(&act_q);
      found    = 1'b0;
      for (int i = 0; i < N_OBS; i++) begin
         if (spawn_ok && !found && !act_q[i]) begin
            x_nxt[i]   = X_W'(X_START);
            act_nxt[i] = 1'b1;
            found      = 1'b1;
         end
      end
      if (found) begin
         gap_nxt = '0;
      end else if (gap_q == '1) begin
         gap_nxt = gap_q;
      end else begin
         gap_nxt = gap_q + GAP_W'(1);
      end

      lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

      collide = 1'b0;
      for (int i = 0; i < N_OBS; i++) begin
         if (act_nxt[i] && (x_nxt[i] == X_W'(PLAYER_X)) && (32'(y_nxt) < OBS_H)) begin
            collide = 1'b1;
         end
      end
   end

   // Game state machine with its registered datapath and status outputs.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         y_q     <= '0;
         vel_q   <= '0;
         x_q     <= '0;
         act_q   <= '0;
         lives_q <= '0;
         score_q <= '0;
         hit_q   <= 1'b0;
         over_q  <= 1'b0;
         lfsr_q  <= 16'hACE1;
         gap_q   <= '0;
         pend_q  <= 1'b0;
         wait_q  <= '0;
      end else begin
         hit_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) state_q <= StInit;
            end
            StInit, StRespawn: begin
               if (state_q == StInit) begin
                  lives_q <= 4'(LIVES);
                  score_q <= '0;
               end
               y_q     <= '0;
               vel_q   <= '0;
               act_q   <= '0;
               gap_q   <= '0;
               pend_q  <= 1'b0;
               state_q <= StPlay;
            end
            StPlay: begin
               if (tick) begin
                  y_q     <= y_nxt;
                  vel_q   <= vel_nxt;
                  x_q     <= x_nxt;
                  act_q   <= act_nxt;
                  score_q <= score_q + SCORE_W'(cleared);
                  lfsr_q  <= lfsr_nxt;
                  gap_q   <= gap_nxt;
                  if (collide) begin
                     state_q <= StHit;
                     hit_q   <= 1'b1;
                  end
               end
               // A request stays pending until consumed by a ground-level tick.
               pend_q <= jump_edge | (pend_q & ~(tick & jump_now));
            end
            StHit: begin
               lives_q <= lives_dec;
               wait_q  <= '0;
               if (lives_dec == 4'd0) begin
                  state_q <= StOver;
                  over_q  <= 1'b1;
               end else begin
                  state_q <= StDeadWait;
               end
            end
            StDeadWait: begin
               if (tick) begin
                  if (wait_q == WAIT_W'(DEAD_TICKS - 1)) begin
                     state_q <= StRespawn;
                  end else begin
                     wait_q <= wait_q + WAIT_W'(1);
                  end
               end
            end
            StOver: begin
               if (start) begin
                  state_q <= StInit;
                  over_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_runner_game_core.sv
// Randomized bench for runner_game_core against a cycle-level behavioural model.
module tb_runner_game_core;

   localparam int TICK_DIV   = 4;
   localparam int H_W        = 7;
   localparam int JUMP_V     = 6;
   localparam int GRAVITY    = 1;
   localparam int N_OBS      = 2;
   localparam int X_W        = 8;
   localparam int X_START    = 159;
   localparam int PLAYER_X   = 20;
   localparam int OBS_H      = 8;
   localparam int MIN_GAP    = 0;
   localparam int LIVES      = 2;
   localparam int DEAD_TICKS = 2;
   localparam int SCORE_W    = 16;
   localparam int Y_MAX      = (1 << H_W) - 1;
   localparam int NCYC       = 24000;

   localparam int S_IDLE = 0, S_INIT = 1, S_RESPAWN = 2, S_PLAY = 3;
   localparam int S_HIT = 4, S_DEAD = 5, S_OVER = 6;

   logic                 clock, resetn, start, jump;
   logic [2:0]           state;
   logic                 tick;
   logic [H_W-1:0]       player_y;
   logic [N_OBS*X_W-1:0] obs_x;
   logic [N_OBS-1:0]     obs_active;
   logic [3:0]           lives_left;
   logic [SCORE_W-1:0]   score;
   logic                 hit, game_over;

   runner_game_core #(
      .TICK_DIV(TICK_DIV), .H_W(H_W), .JUMP_V(JUMP_V), .GRAVITY(GRAVITY), .N_OBS(N_OBS),
      .X_W(X_W), .X_START(X_START), .PLAYER_X(PLAYER_X), .OBS_H(OBS_H), .MIN_GAP(MIN_GAP),
      .LIVES(LIVES), .DEAD_TICKS(DEAD_TICKS), .SCORE_W(SCORE_W)
   ) dut (
      .clock(clock), .resetn(resetn), .start(start), .jump(jump), .state(state),
      .tick(tick), .player_y(player_y), .obs_x(obs_x), .obs_active(obs_active),
      .lives_left(lives_left), .score(score), .hit(hit), .game_over(game_over)
   );

   always #5 clock = ~clock;

   int n_vec, n_err;

   // Model state in plain integers.
   int m_state, m_div, m_y, m_v, m_lives, m_score, m_lfsr, m_gap, m_wait;
   int m_x[N_OBS];
   bit m_act[N_OBS];
   bit m_pend, m_jprev;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_div = 0; m_y = 0; m_v = 0; m_lives = 0; m_score = 0;
      m_lfsr = 'hACE1; m_gap = 0; m_wait = 0; m_pend = 0; m_jprev = 0;
      for (int i = 0; i < N_OBS; i++) begin
         m_x[i] = 0;
         m_act[i] = 0;
      end
   endtask

   task automatic model_step(input bit s, input bit j);
      bit t, edge_seen, consume, crash;
      bit old_act[N_OBS];
      int vel, ny, free_idx, fb;
      t = (m_div == TICK_DIV - 1);
      edge_seen = j && !m_jprev;
      consume = 0;
      crash = 0;
      case (m_state)
         S_IDLE: if (s) m_state = S_INIT;
         S_INIT, S_RESPAWN: begin
            if (m_state == S_INIT) begin
               m_lives = LIVES;
               m_score = 0;
            end
            m_y = 0; m_v = 0; m_gap = 0; m_pend = 0;
            for (int i = 0; i < N_OBS; i++) m_act[i] = 0;
            m_state = S_PLAY;
         end
         S_PLAY: begin
            if (t) begin
               vel = m_v;
               if (m_y == 0 && m_pend) begin
                  vel = JUMP_V;
                  consume = 1;
               end
               ny = m_y + vel;
               if (ny <= 0) begin
                  m_y = 0; m_v = 0;
               end else if (ny > Y_MAX) begin
                  m_y = Y_MAX; m_v = 0;
               end else begin
                  m_y = ny; m_v = vel - GRAVITY;
               end
               for (int i = 0; i < N_OBS; i++) old_act[i] = m_act[i];
               for (int i = 0; i < N_OBS; i++) begin
                  if (old_act[i]) begin
                     if (m_x[i] == 0) begin
                        m_act[i] = 0;
                        m_score = (m_score + 1) % (1 << SCORE_W);
                     end else begin
                        m_x[i] = m_x[i] - 1;
                     end
                  end
               end
               free_idx = -1;
               if ((m_lfsr & 'hF) == 0 && m_gap >= MIN_GAP) begin
                  for (int i = N_OBS - 1; i >= 0; i--) if (!old_act[i]) free_idx = i;
               end
               if (free_idx >= 0) begin
                  m_x[free_idx] = X_START;
                  m_act[free_idx] = 1;
                  m_gap = 0;
               end else if (m_gap < MIN_GAP) begin
                  m_gap = m_gap + 1;
               end
               fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
               m_lfsr = ((m_lfsr << 1) | fb) & 'hFFFF;
               for (int i = 0; i < N_OBS; i++)
                  if (m_act[i] && m_x[i] == PLAYER_X && m_y < OBS_H) crash = 1;
               if (crash) m_state = S_HIT;
            end
            m_pend = edge_seen || (m_pend && !consume);
         end
         S_HIT: begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_wait = 0;
            m_state = (m_lives == 0) ? S_OVER : S_DEAD;
         end
         S_DEAD: begin
            if (t) begin
               m_wait++;
               if (m_wait == DEAD_TICKS) m_state = S_RESPAWN;
            end
         end
         S_OVER: if (s) m_state = S_INIT;
         default: m_state = S_IDLE;
      endcase
      m_div = t ? 0 : m_div + 1;
      m_jprev = j;
   endtask

   task automatic compare_all();
      logic [N_OBS*X_W-1:0] ex;
      logic [N_OBS-1:0] ea;
      for (int i = 0; i < N_OBS; i++) begin
         ex[i*X_W +: X_W] = X_W'(m_x[i]);
         ea[i] = m_act[i];
      end
      check_eq("state", 32'(state), 32'(m_state));
      check_eq("tick", 32'(tick), 32'(m_div == TICK_DIV - 1));
      check_eq("player_y", 32'(player_y), 32'(m_y));
      check_eq("obs_x", 32'(obs_x), 32'(ex));
      check_eq("obs_active", 32'(obs_active), 32'(ea));
      check_eq("lives_left", 32'(lives_left), 32'(m_lives));
      check_eq("score", 32'(score), 32'(m_score));
      check_eq("hit", 32'(hit), 32'(m_state == S_HIT));
      check_eq("game_over", 32'(game_over), 32'(m_state == S_OVER));
   endtask

   initial begin
      int mode;
      bit did_reset;
      n_vec = 0; n_err = 0; did_reset = 0;
      clock = 0; resetn = 0; start = 0; jump = 0;
      model_reset();
      repeat (2) @(negedge clock);
      compare_all();
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (!resetn) resetn = 1;
         mode = (cyc / 2000) % 4;
         start = ($urandom_range(0, 31) == 0);
         case (mode)
            0: jump = 0;
            1: jump = 1;
            2: jump = $urandom_range(0, 1);
            default: if ($urandom_range(0, 39) == 0) jump = ~jump;
         endcase
         model_step(start, jump);
         @(negedge clock);
         compare_all();
         // Asynchronous reset in the middle of a game.
         if (m_state == S_PLAY &&
             ((!did_reset && cyc > 3000) || $urandom_range(0, 4999) == 0)) begin
            did_reset = 1;
            resetn = 0;
            #1;
            model_reset();
            compare_all();
            @(negedge clock);
            compare_all();
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
